// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM encoding,
// status word field offsets and the lowest-set-index helper.
package pll_rst_seq_pkg;

   localparam int unsigned MAX_PLL = 8;
   localparam int unsigned CUR_W   = 3;

   // status read-back word layout
   localparam int unsigned ST_LOCK_LSB = 0;
   localparam int unsigned ST_DONE_LSB = 8;
   localparam int unsigned ST_TMO_LSB  = 16;
   localparam int unsigned ST_BUSY_BIT = 24;
   localparam int unsigned ST_CUR_LSB  = 25;
   localparam int unsigned ST_LOL_LSB  = 28;
   localparam int unsigned ST_LOL_W    = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ASSERT    = 2'd1,
      WAIT_LOCK = 2'd2
   } seq_state_e;

   function automatic logic [CUR_W-1:0] lowest_idx(input logic [MAX_PLL-1:0] v);
      logic [CUR_W-1:0] idx;
      logic             found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_PLL; i++) begin
         if (v[i] && !found) begin
            idx   = CUR_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/pll_rst_sync2.sv
// Two-flop synchronizer bank bringing the raw PLL locked flags into the clk domain.
module pll_rst_sync2 #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_rst_seq.sv
// Turns software reset-request edges into timed pll_areset pulses, one PLL at a time,
// waits for relock with timeout. Optional auto-restart on loss of lock: PLL_RST_SEQ_LOL_RESTART_EN.
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int unsigned N_PLL        = 4,
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 65536,
   parameter int unsigned CNT_W        = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      rst_req,
   input  logic [N_PLL-1:0] pll_locked,
   output logic [N_PLL-1:0] pll_areset,
   output logic             busy,
   output logic [31:0]      status
);

   seq_state_e         state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [CUR_W-1:0]   cur, cur_nx;
   logic               pick, fin_lock, fin_tmo;

   logic [N_PLL-1:0]   lock_s, req_d, rise;
   logic [N_PLL-1:0]   pending, done, tmo;
   logic [N_PLL-1:0]   pend_nx, done_nx, tmo_nx;
   logic [N_PLL-1:0]   lol_set, cur_oh, pick_oh;
   logic [MAX_PLL-1:0] lock_pad, pend_pad;
   logic [ST_LOL_W-1:0] lol_field;

   logic [N_PLL-1:0]   areset_nx;
   logic               busy_nx;
   logic [31:0]        status_nx;

   // only rst_req[N_PLL-1:0] is meaningful; the rest is sunk here
   logic               unused_req;
   assign unused_req = ^rst_req;

   pll_rst_sync2 #(.W(N_PLL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_locked),
      .q     (lock_s)
   );

   assign lock_pad = MAX_PLL'(lock_s);
   assign pend_pad = MAX_PLL'(pending);
   assign cur_oh   = N_PLL'(1) << cur;
   assign pick_oh  = N_PLL'(1) << cur_nx;
   assign rise     = rst_req[N_PLL-1:0] & ~req_d;

`ifdef PLL_RST_SEQ_LOL_RESTART_EN
   logic [N_PLL-1:0] lock_d, lol, in_svc;

   // a falling lock on a PLL that finished service and is not being serviced now
   assign in_svc    = (state != IDLE) ? cur_oh : '0;
   assign lol_set   = lock_d & ~lock_s & done & ~in_svc;
   assign lol_field = ST_LOL_W'(lol);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_d <= '0;
         lol    <= '0;
      end else begin
         lock_d <= lock_s;
         lol    <= lol | lol_set;
      end
   end
`else
   assign lol_set   = '0;
   assign lol_field = '0;
`endif

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cur   <= cur_nx;
      end
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cur_nx   = cur;
      pick     = 1'b0;
      fin_lock = 1'b0;
      fin_tmo  = 1'b0;
      unique case (state)
         IDLE: begin
            if (|pending) begin
               pick     = 1'b1;
               cur_nx   = lowest_idx(pend_pad);
               cnt_nx   = CNT_W'(RST_CYCLES - 1);
               state_nx = ASSERT;
            end
         end
         ASSERT: begin
            if (cnt == '0) begin
               cnt_nx   = CNT_W'(LOCK_TIMEOUT - 1);
               state_nx = WAIT_LOCK;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_pad[cur]) begin
               fin_lock = 1'b1;
               state_nx = IDLE;
            end else if (cnt == '0) begin
               fin_tmo  = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM: outputs, registered one cycle behind the state
   always_comb begin
      areset_nx = '0;
      if (state == ASSERT) areset_nx = cur_oh;
      busy_nx = (state_nx != IDLE);
   end

   // request bookkeeping; new requests win over the clear at pick time
   always_comb begin
      pend_nx = pending;
      done_nx = done;
      tmo_nx  = tmo;
      if (pick) begin
         pend_nx = pend_nx & ~pick_oh;
         done_nx = done_nx & ~pick_oh;
         tmo_nx  = tmo_nx & ~pick_oh;
      end
      if (fin_lock) done_nx = done_nx | cur_oh;
      if (fin_tmo)  tmo_nx  = tmo_nx | cur_oh;
      pend_nx = pend_nx | rise | lol_set;
   end

   always_comb begin
      status_nx = '0;
      status_nx[ST_LOCK_LSB +: MAX_PLL]  = lock_pad;
      status_nx[ST_DONE_LSB +: MAX_PLL]  = MAX_PLL'(done);
      status_nx[ST_TMO_LSB +: MAX_PLL]   = MAX_PLL'(tmo);
      status_nx[ST_BUSY_BIT]             = busy;
      status_nx[ST_CUR_LSB +: CUR_W]     = cur;
      status_nx[ST_LOL_LSB +: ST_LOL_W]  = lol_field;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_d   <= '0;
         pending <= '0;
         done    <= '0;
         tmo     <= '0;
      end else begin
         req_d   <= rst_req[N_PLL-1:0];
         pending <= pend_nx;
         done    <= done_nx;
         tmo     <= tmo_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pll_areset <= '0;
         busy       <= 1'b0;
         status     <= '0;
      end else begin
         pll_areset <= areset_nx;
         busy       <= busy_nx;
         status     <= status_nx;
      end
   end

endmodule
